button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive cycles a synchronized level must differ before it is accepted (legal range 1..255).
REQ-002 The block SHALL have port CLK  input  1  the single system clock; all flops are rising-edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port raw_0  input  1  asynchronous mechanical button "0", active-high.
REQ-005 The block SHALL have port raw_1  input  1  asynchronous mechanical button "1", active-high.
REQ-006 The block SHALL have port but_0  output  1  one-cycle press pulse for button 0, fed directly to the lock FSM input but_0.
REQ-007 The block SHALL have port but_1  output  1  one-cycle press pulse for button 1, fed directly to the lock FSM input but_1.
REQ-008 The block SHALL have port conflict  output  1  one-cycle pulse that flags a simultaneous press; both but_0 and but_1 are suppressed in that cycle.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Each channel SHALL hold a debounced level "stable" and a counter "cnt" (8 bits).
REQ-011 When sync2 == stable, the counter SHALL clear to 0.
REQ-012 When sync2 != stable and cnt == DEBOUNCE_CYCLES-1, the channel SHALL set stable <= sync2 and cnt <= 0; when cnt is below that value, the channel SHALL increment cnt.
REQ-013 A channel SHALL raise a rise event when stable goes 0->1; a stable 1->0 transition (release) SHALL produce no output.
REQ-014 Registered outputs SHALL be: but_x = rise_x & ~stable_other; conflict = rise_0 & stable_1 | rise_1 & stable_0 (this includes simultaneous rises).
REQ-015 Latency SHALL be: with raw held high and first sampled at edge k, stable=1 after edge k+1+N and but_x=1 for exactly the one cycle after edge k+2+N (N=DEBOUNCE_CYCLES).
REQ-016 A raw pulse or bounce whose synchronized level lasts fewer than N cycles SHALL produce no output, and its count SHALL be discarded.
REQ-017 A button held indefinitely SHALL produce exactly one pulse; a further pulse SHALL require a release to be debounced first.
REQ-018 At most one of but_0, but_1, conflict SHALL be high in any cycle.

Reset
REQ-019 Asserting RESET (low) SHALL immediately clear sync1, sync2, stable, cnt, but_0, but_1 and conflict to 0, regardless of the clock.
REQ-020 Reset asserted mid-debounce SHALL abandon the count, and no pulse SHALL be emitted for that press.
REQ-021 A button held high through reset release SHALL be treated as a new press, with its pulse after edge N+2 counted from the first post-reset edge.

Configuration
REQ-022 Macro BTN_DEBOUNCE_EN defined: the debounce counter SHALL be present as described in REQ-010..REQ-016.
REQ-023 Macro BTN_DEBOUNCE_EN undefined: the counter SHALL be omitted, stable <= sync2 every cycle, and latency SHALL equal the N=1 case (pulse after edge k+3); DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-024 Shared package btn_cond_pkg SHALL hold CNT_W = 8 and DEFAULT_DEBOUNCE = 4.
REQ-025 Sub-module btn_channel (synchronizer + debounce + rise detect) SHALL be instantiated twice.
REQ-026 Conflict and mutual-exclusion logic SHALL live in the top level.

Verification
REQ-027 Scenario 1: N=4, raw_0 high for 20 cycles -> but_0 high for exactly 1 cycle after edge k+6; but_1=conflict=0 throughout.
REQ-028 Scenario 2: raw_1 toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during the bounce; exactly one but_1 pulse 6 edges after the final sync-stable sample.
REQ-029 Scenario 3: raw_0 and raw_1 rise on the same edge -> conflict=1 for one cycle, but_0=but_1=0; releasing both produces no output.
REQ-030 Scenario 4: raw_0 held, RESET pulsed low at edge k+3, raw_0 still high after release -> no pulse before reset; one but_0 pulse 6 edges after reset release.
REQ-031 Scenario 5: press sequence 0,1,0,1,1 (each held 8 cycles, released 8 cycles) into the lock FSM -> pulse train but_0/but_1 = 10100/01011 and UNLOCK asserts.
REQ-032 Scenario 6: BTN_DEBOUNCE_EN undefined, 1-cycle raw_0 glitch -> but_0 pulse after edge k+3.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// ---------------------------------------------------------------------------
// btn_cond_pkg : shared widths, defaults and channel status type for the
//                button conditioner.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btn_cond_pkg;

  localparam int CNT_W            = 8;
  localparam int DEFAULT_DEBOUNCE = 4;

  typedef struct packed {
    logic stable;
    logic rise;
  } chan_status_t;

  function automatic logic debounce_cfg_ok(input int unsigned cycles);
    return (cycles >= 1) && (cycles <= (2 ** CNT_W) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel : 2-flop synchronizer, debounce (BTN_DEBOUNCE_EN), rise detect.
//               Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         raw_i,
  output chan_status_t status_o
);

  if (!debounce_cfg_ok(DEBOUNCE_CYCLES)) begin : g_bad_debounce_cycles
    $error("btn_channel: DEBOUNCE_CYCLES out of range");
  end

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_d;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronized level agrees with stable discards the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stable_d = sync2_q;
`endif

  assign status_o.stable = stable_q;
  assign status_o.rise   = stable_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner : two debounced buttons -> press pulses plus a conflict
//                      flag.  Debounce counter enabled by BTN_DEBOUNCE_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_0,
  input  logic raw_1,
  output logic but_0,
  output logic but_1,
  output logic conflict
);

  if (!debounce_cfg_ok(DEBOUNCE_CYCLES)) begin : g_bad_debounce_cycles
    $error("button_conditioner: DEBOUNCE_CYCLES out of range");
  end

  chan_status_t st0;
  chan_status_t st1;

  btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch0 (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .raw_i    (raw_0),
    .status_o (st0)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .raw_i    (raw_1),
    .status_o (st1)
  );

  logic but_0_d;
  logic but_1_d;
  logic conflict_d;
  logic but_0_q;
  logic but_1_q;
  logic conflict_q;

  // A press only counts while the other button is released; otherwise it is a conflict.
  always_comb begin
    but_0_d    = st0.rise & ~st1.stable;
    but_1_d    = st1.rise & ~st0.stable;
    conflict_d = (st0.rise & st1.stable) | (st1.rise & st0.stable);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      but_0_q    <= 1'b0;
      but_1_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      but_0_q    <= but_0_d;
      but_1_q    <= but_1_d;
      conflict_q <= conflict_d;
    end
  end

  assign but_0    = but_0_q;
  assign but_1    = but_1_q;
  assign conflict = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner : self-checking bench with a windowed behavioural model.
//                         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;

  localparam int unsigned N = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int NE = N;
`else
  localparam int NE = 1;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic raw_0 = 1'b0;
  logic raw_1 = 1'b0;
  logic but_0;
  logic but_1;
  logic conflict;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .raw_0    (raw_0),
    .raw_1    (raw_1),
    .but_0    (but_0),
    .but_1    (but_1),
    .conflict (conflict)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: synced level = raw two edges late; stable flips once the last NE
  // synced samples all disagree with it; outputs follow one edge after a rise.
  logic [1:0]   m_d1, m_d2, m_stab, m_prev;
  logic [255:0] m_win [2];
  logic         e_b0, e_b1, e_cf;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_stab = '0; m_prev = '0;
    m_win[0] = '0; m_win[1] = '0;
    e_b0 = 1'b0; e_b1 = 1'b0; e_cf = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] raw);
    logic [255:0] mask;
    logic [1:0]   rise;
    logic         nst;
    mask = '0;
    for (int i = 0; i < NE; i++) mask[i] = 1'b1;
    rise = m_stab & ~m_prev;
    e_b0 = rise[0] & ~m_stab[1];
    e_b1 = rise[1] & ~m_stab[0];
    e_cf = (rise[0] & m_stab[1]) | (rise[1] & m_stab[0]);
    for (int c = 0; c < 2; c++) begin
      m_win[c] = {m_win[c][254:0], m_d2[c]};
      nst = m_stab[c];
      if (!m_stab[c] && ((m_win[c] & mask) == mask)) nst = 1'b1;
      if (m_stab[c] && ((m_win[c] & mask) == '0)) nst = 1'b0;
      m_prev[c] = m_stab[c];
      m_stab[c] = nst;
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  int       step_no, n_b0, n_b1, n_cf, first_b0, first_b1;
  logic [4:0] p0, p1;

  task automatic clr_stats();
    step_no = 0; n_b0 = 0; n_b1 = 0; n_cf = 0; first_b0 = 0; first_b1 = 0;
    p0 = '0; p1 = '0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic r0, input logic r1);
    raw_0 = r0;
    raw_1 = r1;
    @(posedge CLK);
    model_edge({r1, r0});
    #1;
    step_no++;
    check("but_0", 32'(but_0), 32'(e_b0));
    check("but_1", 32'(but_1), 32'(e_b1));
    check("conflict", 32'(conflict), 32'(e_cf));
    check("exclusive", 32'(int'(but_0) + int'(but_1) + int'(conflict) <= 1), 32'd1);
    if (but_0) begin n_b0++; if (first_b0 == 0) first_b0 = step_no; end
    if (but_1) begin n_b1++; if (first_b1 == 0) first_b1 = step_no; end
    if (conflict) n_cf++;
    if (but_0 || but_1) begin p0 = {p0[3:0], but_0}; p1 = {p1[3:0], but_1}; end
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    #2 RESET = 1'b0;
    #1;
    check("rst_but_0", 32'(but_0), 32'd0);
    check("rst_but_1", 32'(but_1), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic repeat_step(input int n, input logic r0, input logic r1);
    for (int i = 0; i < n; i++) step(r0, r1);
  endtask

  initial begin
    logic r0, r1;
    model_reset();
    clr_stats();
    #1;
    check("init_but_0", 32'(but_0), 32'd0);
    check("init_but_1", 32'(but_1), 32'd0);
    check("init_conflict", 32'(conflict), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    // Single press held for 20 cycles
    clr_stats();
    repeat_step(20, 1'b1, 1'b0);
    check("s1_n_b0", 32'(n_b0), 32'd1);
    check("s1_latency", 32'(first_b0), 32'(3 + NE));
    check("s1_n_b1", 32'(n_b1 + n_cf), 32'd0);
    repeat_step(12, 1'b0, 1'b0);
    check("s1_release", 32'(n_b0), 32'd1);

    // Bounce on raw_1, then hold
    clr_stats();
    for (int i = 0; i < 2; i++) begin
      repeat_step(2, 1'b0, 1'b1);
      repeat_step(2, 1'b0, 1'b0);
    end
    repeat_step(20, 1'b0, 1'b1);
    check("s2_n_b1", 32'(n_b1), 32'((NE > 2) ? 1 : 3));
    check("s2_n_b0", 32'(n_b0 + n_cf), 32'd0);
    repeat_step(12, 1'b0, 1'b0);

    // Simultaneous press
    clr_stats();
    repeat_step(12, 1'b1, 1'b1);
    repeat_step(12, 1'b0, 1'b0);
    check("s3_n_cf", 32'(n_cf), 32'd1);
    check("s3_n_b", 32'(n_b0 + n_b1), 32'd0);

    // Reset mid-debounce with button held through release
    clr_stats();
    repeat_step(3, 1'b1, 1'b0);
    raw_0 = 1'b1;
    apply_reset();
    check("s4_pre_reset", 32'(n_b0), 32'd0);
    clr_stats();
    repeat_step(20, 1'b1, 1'b0);
    check("s4_n_b0", 32'(n_b0), 32'd1);
    check("s4_latency", 32'(first_b0), 32'(3 + NE));
    repeat_step(12, 1'b0, 1'b0);

    // Lock code sequence 0,1,0,1,1
    clr_stats();
    for (int i = 0; i < 5; i++) begin
      r1 = (i == 1) || (i == 3) || (i == 4);
      repeat_step(8, ~r1, r1);
      repeat_step(8, 1'b0, 1'b0);
    end
    check("s5_p0", 32'(p0), 32'(5'b10100));
    check("s5_p1", 32'(p1), 32'(5'b01011));

    // Randomized toggling with occasional reset
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 4) == 0) r1 = ~r1;
      step(r0, r1);
      if ($urandom_range(0, 99) == 0) begin
        raw_0 = r0;
        raw_1 = r1;
        apply_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
